// File: rtl/pled_pwm_driver.sv
// pled_pwm_driver
//
// Purpose: PWM driver for a power LED. A free-running prescaler produces one
// PWM step (tick_o) every 2^PRESCALE_W clocks. A PWM_W-bit step counter runs
// through 2^PWM_W steps per period. pwm_o is registered as
// (pwm_counter < cur_duty). A new duty is accepted through a valid/ready
// handshake. It takes effect only on a period boundary, so a PWM period is
// never cut short.
//
// Optional feature: define macro PLED_FADE_EN to fade cur_duty by +/-1 per
// period toward the requested duty instead of jumping straight to it.
//
// Ports:
//   clk_i          - single clock, all logic on its rising edge
//   rst_i          - asynchronous active-high reset
//   duty_i         - requested target duty (PWM_W bits)
//   duty_valid_i   - duty_i valid this cycle
//   duty_ready_o   - block accepts a new duty this cycle (FSM idle)
//   pwm_o          - registered PWM drive
//   pwm_counter_o  - current PWM step (debug probe bus)
//   prescale_msb_o - prescaler MSB (debug sample clock)
//   tick_o         - one-cycle pulse per PWM step
//   busy_o         - a duty change is pending or ramping
module pled_pwm_driver #(
  parameter int PRESCALE_W = 12,
  parameter int PWM_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PWM_W-1:0] duty_i,
  input  logic             duty_valid_i,
  output logic             duty_ready_o,
  output logic             pwm_o,
  output logic [PWM_W-1:0] pwm_counter_o,
  output logic             prescale_msb_o,
  output logic             tick_o,
  output logic             busy_o
);

  localparam logic [PRESCALE_W-1:0] PRE_ONE = 1;
  localparam logic [PWM_W-1:0]      PWM_ONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RAMP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PWM_W-1:0]      pwm_counter_q, pwm_counter_d;
  logic [PWM_W-1:0]      cur_duty_q, cur_duty_d;
  logic [PWM_W-1:0]      target_q, target_d;
  logic                  pwm_q, pwm_d;

  logic tick;
  logic boundary;
  logic accept;
  logic at_target;

  // ---------------------------------------------------------------------------
  // Timebase: independent of the FSM.
  // ---------------------------------------------------------------------------
  assign tick     = &prescale_q;
  assign boundary = tick & (&pwm_counter_q);

  always_comb begin
    prescale_d    = prescale_q + PRE_ONE;
    pwm_counter_d = pwm_counter_q;
    if (tick) begin
      pwm_counter_d = pwm_counter_q + PWM_ONE;
    end
    pwm_d = (pwm_counter_q < cur_duty_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prescale_q    <= '0;
      pwm_counter_q <= '0;
      pwm_q         <= 1'b0;
    end else begin
      prescale_q    <= prescale_d;
      pwm_counter_q <= pwm_counter_d;
      pwm_q         <= pwm_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Duty datapath
  // ---------------------------------------------------------------------------
  assign accept    = duty_valid_i & (state_q == ST_IDLE);
  assign at_target = (target_q == cur_duty_q);

`ifdef PLED_FADE_EN
  logic [PWM_W-1:0] step_duty;
  // One step from cur_duty toward target. The value only matters when the
  // two differ.
  assign step_duty = (target_q > cur_duty_q) ? (cur_duty_q + PWM_ONE)
                                             : (cur_duty_q - PWM_ONE);
`endif

  always_comb begin
    target_d   = target_q;
    cur_duty_d = cur_duty_q;
    if (accept) begin
      target_d = duty_i;
    end
    // cur_duty changes only on a period boundary while a change is pending.
    // A capture made in IDLE on a boundary cycle cannot move cur_duty there.
    // It is first seen in WAIT at the following boundary.
    if (boundary && !at_target) begin
`ifdef PLED_FADE_EN
      // The boundary that ends WAIT is already the first fade step.
      if (state_q == ST_WAIT || state_q == ST_RAMP) begin
        cur_duty_d = step_duty;
      end
`else
      if (state_q == ST_WAIT) begin
        cur_duty_d = target_q;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_duty_q <= '0;
      target_q   <= '0;
    end else begin
      cur_duty_q <= cur_duty_d;
      target_q   <= target_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (boundary) begin
          if (at_target) begin
            state_d = ST_IDLE;
          end else begin
`ifdef PLED_FADE_EN
            state_d = (step_duty == target_q) ? ST_IDLE : ST_RAMP;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      ST_RAMP: begin
`ifdef PLED_FADE_EN
        if (boundary && (at_target || step_duty == target_q)) begin
          state_d = ST_IDLE;
        end
`else
        // Never entered without fading; recover to IDLE if it is.
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    duty_ready_o = (state_q == ST_IDLE);
    busy_o       = (state_q == ST_WAIT) || (state_q == ST_RAMP);
  end

  // ---------------------------------------------------------------------------
  // Remaining outputs
  // ---------------------------------------------------------------------------
  assign pwm_o          = pwm_q;
  assign pwm_counter_o  = pwm_counter_q;
  assign prescale_msb_o = prescale_q[PRESCALE_W-1];
  assign tick_o         = tick;

endmodule

// File: tb/tb_pled_pwm_driver.sv
module tb_pled_pwm_driver;

  localparam int PRESCALE_W = 2;
  localparam int PWM_W      = 4;
  localparam int STEP       = 4;   // clocks per PWM step
  localparam int PERIOD     = 64;  // clocks per PWM period

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [PWM_W-1:0] duty_i = '0;
  logic             duty_valid_i = 1'b0;
  logic             duty_ready_o;
  logic             pwm_o;
  logic [PWM_W-1:0] pwm_counter_o;
  logic             prescale_msb_o;
  logic             tick_o;
  logic             busy_o;

  always #5 clk_i = ~clk_i;

  pled_pwm_driver #(
    .PRESCALE_W(PRESCALE_W),
    .PWM_W     (PWM_W)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .duty_i        (duty_i),
    .duty_valid_i  (duty_valid_i),
    .duty_ready_o  (duty_ready_o),
    .pwm_o         (pwm_o),
    .pwm_counter_o (pwm_counter_o),
    .prescale_msb_o(prescale_msb_o),
    .tick_o        (tick_o),
    .busy_o        (busy_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model. Time is a clock count since reset release. Every
  // counter follows from that count by division. The duty side is a target,
  // a current duty and a pending flag that resolves at period ends.
  int m_n      = 0;  // rising edges since reset release
  int m_cur    = 0;
  int m_target = 0;
  bit m_busy   = 0;
  bit m_pwm    = 0;

  task automatic model_reset();
    m_n = 0; m_cur = 0; m_target = 0; m_busy = 0; m_pwm = 0;
  endtask

  task automatic model_edge();
    bit period_end;
    period_end = (m_n % PERIOD) == PERIOD - 1;
    m_pwm = ((m_n / STEP) % 16) < m_cur;
    if (m_busy) begin
      if (period_end) begin
        if (m_cur == m_target) m_busy = 0;
        else begin
`ifdef PLED_FADE_EN
          m_cur = m_cur + ((m_target > m_cur) ? 1 : -1);
          if (m_cur == m_target) m_busy = 0;
`else
          m_cur  = m_target;
          m_busy = 0;
`endif
        end
      end
    end else if (duty_valid_i) begin
      m_target = int'(duty_i);
      m_busy   = 1;
    end
    m_n++;
  endtask

  task automatic check_outputs();
    check_eq("tick",        int'(tick_o),         int'((m_n % STEP) == STEP - 1));
    check_eq("pwm_counter", int'(pwm_counter_o),  (m_n / STEP) % 16);
    check_eq("prescale_msb",int'(prescale_msb_o), int'((m_n % STEP) >= STEP / 2));
    check_eq("pwm",         int'(pwm_o),          int'(m_pwm));
    check_eq("busy",        int'(busy_o),         int'(m_busy));
    check_eq("ready",       int'(duty_ready_o),   int'(!m_busy));
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && m_busy; i++) cycle();
  endtask

  task automatic write_duty(input int d);
    wait_idle();
    duty_i       = d[PWM_W-1:0];
    duty_valid_i = 1'b1;
    cycle();
    duty_valid_i = 1'b0;
  endtask

  // Counts DUT pwm highs over one full period of clocks.
  task automatic pwm_window(input string tag, input int exp);
    int cnt;
    cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      cycle();
      cnt += int'(pwm_o);
    end
    check_eq(tag, cnt, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pwm"},   int'(pwm_o),          0);
    check_eq({tag, "_tick"},  int'(tick_o),         0);
    check_eq({tag, "_busy"},  int'(busy_o),         0);
    check_eq({tag, "_ready"}, int'(duty_ready_o),   1);
    check_eq({tag, "_cnt"},   int'(pwm_counter_o),  0);
    check_eq({tag, "_msb"},   int'(prescale_msb_o), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    #12;
    check_reset_outputs("rst0");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();

    // Free-running timebase through a couple of periods.
    run(2 * PERIOD + 10);

    // Duty 5: busy at once, 20 of 64 clocks high once settled.
    write_duty(5);
    check_eq("busy_after_write", int'(busy_o), 1);
    wait_idle();
    run(PERIOD);
    pwm_window("pwm_high_duty5", 20);
    check_eq("ready_after_5", int'(duty_ready_o), 1);

    // 0 -> 3 -> 0.
    write_duty(0);
    wait_idle();
    write_duty(3);
    wait_idle();
    run(PERIOD);
    pwm_window("pwm_high_duty3", 12);
    write_duty(0);
    wait_idle();
    run(PERIOD);
    pwm_window("pwm_high_duty0", 0);

    // Duty 9 held valid while busy: ignored until ready, then accepted.
    write_duty(12);
    duty_i       = 4'd9;
    duty_valid_i = 1'b1;
    for (int i = 0; i < 3000 && m_target != 9; i++) cycle();
    duty_valid_i = 1'b0;
    check_eq("target9_accepted", m_target, 9);
    wait_idle();
    run(PERIOD);
    pwm_window("pwm_high_duty9", 36);

    // Capture on the boundary cycle: takes effect a full period later.
    while ((m_n % PERIOD) != PERIOD - 1) cycle();
    duty_i       = 4'd10;
    duty_valid_i = 1'b1;
    cycle();
    duty_valid_i = 1'b0;
    check_eq("busy_boundary_capture", int'(busy_o), 1);
    run(PERIOD - 1);
    check_eq("busy_before_next_boundary", int'(busy_o), 1);
    wait_idle();
    run(PERIOD);
    pwm_window("pwm_high_duty10", 40);

    // Random writes, many landing while busy.
    for (int i = 0; i < 3000; i++) begin
      duty_valid_i = ($urandom_range(0, 15) == 0);
      duty_i       = PWM_W'($urandom_range(0, 15));
      cycle();
    end
    duty_valid_i = 1'b0;
    wait_idle();

    // Reset in the middle of a change (cur 2 after one step under fading).
    write_duty(1);
    wait_idle();
    write_duty(7);
    while ((m_n % PERIOD) != 0) cycle();
    run(10);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("rst_held");
    rst_i = 1'b0;
    model_reset();
    run(3 * PERIOD);
    pwm_window("pwm_high_after_rst", 0);
    write_duty(6);
    wait_idle();
    run(PERIOD);
    pwm_window("pwm_high_duty6", 24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pled_pwm_driver.md
PLED_PWM_DRIVER -- requirements
Module: pled_pwm_driver

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 12, prescaler width; one PWM step every 2^PRESCALE_W clocks.
REQ-002 SHALL have parameter PWM_W, default 4, PWM counter and duty width.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port duty_i, input, PWM_W bits: requested target duty.
REQ-006 SHALL have port duty_valid_i, input, 1 bit: duty_i is valid this cycle.
REQ-007 SHALL have port duty_ready_o, output, 1 bit: block accepts a new duty this cycle.
REQ-008 SHALL have port pwm_o, output, 1 bit: registered PWM drive to the power LED.
REQ-009 SHALL have port pwm_counter_o, output, PWM_W bits: current PWM step; this is the debug probe bus.
REQ-010 SHALL have port prescale_msb_o, output, 1 bit: prescaler MSB; this is the debug sample clock.
REQ-011 SHALL have port tick_o, output, 1 bit: one-cycle pulse per PWM step.
REQ-012 SHALL have port busy_o, output, 1 bit: a duty change is pending or ramping.

Function
REQ-013 SHALL use a free-running PRESCALE_W-bit prescaler; +1 per clock, wrapping from all-ones to 0.
REQ-014 SHALL assert tick_o for exactly the cycle in which the prescaler equals all-ones.
REQ-015 SHALL increment pwm_counter on each tick and wrap from 2^PWM_W-1 to 0.
REQ-016 SHALL define the period boundary as tick_o asserted with pwm_counter = 2^PWM_W-1.
REQ-017 SHALL register pwm_o every clock as (pwm_counter < cur_duty), giving 1-clock latency after pwm_counter changes.
REQ-018 SHALL hold pwm_o constantly low at cur_duty = 0; at cur_duty = 2^PWM_W-1, pwm_o SHALL be high for 2^PWM_W-1 of 2^PWM_W steps.
REQ-019 SHALL implement an FSM with states IDLE, WAIT and RAMP.
REQ-020 SHALL drive duty_ready_o = 1 only in IDLE and busy_o = 1 in WAIT or RAMP.
REQ-021 SHALL, on duty_valid_i & duty_ready_o, capture duty_i into target and go IDLE->WAIT; duty_valid_i without ready SHALL be ignored.
REQ-022 SHALL, when a capture coincides with a period boundary, act only from the next boundary.
REQ-023 SHALL, in WAIT at a period boundary with target = cur_duty, go to IDLE with no change.
REQ-024 SHALL update cur_duty only at period boundaries; a PWM period is never truncated.
REQ-025 SHALL NOT let pwm_counter, the prescaler or tick_o depend on FSM state.

Reset
REQ-026 SHALL, on rst_i, clear the prescaler, pwm_counter, cur_duty and target to 0 and set the FSM to IDLE.
REQ-027 SHALL drive outputs during reset to: pwm_o=0, tick_o=0, busy_o=0, duty_ready_o=1, pwm_counter_o=0, prescale_msb_o=0.
REQ-028 SHALL, on reset asserted mid-ramp or in WAIT, discard the pending target; no partial update survives.

Configuration
REQ-029 SHALL honour macro PLED_FADE_EN.
REQ-030 SHALL, when PLED_FADE_EN is defined, go WAIT->RAMP at a boundary if target != cur_duty.
REQ-031 SHALL, in RAMP with PLED_FADE_EN defined, step cur_duty by +/-1 toward target at each boundary and go to IDLE on the boundary where cur_duty reaches target.
REQ-032 SHALL, when PLED_FADE_EN is undefined, load cur_duty <= target at the first boundary in WAIT, then go to IDLE; RAMP SHALL be unreachable.

Verification (bench uses PRESCALE_W=2, PWM_W=4: tick every 4 clk, period 64 clk)
REQ-033 SHALL cover: reset release -> tick_o first at clk 4 after release, then every 4 clk; pwm_counter 0..15 wrap; prescale_msb_o square wave period 4 clk.
REQ-034 SHALL cover, fade off: write duty 5 in IDLE -> busy_o=1 at once; cur_duty=5 at next boundary; pwm_o high 20 of 64 clk per period; duty_ready_o=1 after.
REQ-035 SHALL cover, fade on: duty 0 -> 3 -> cur_duty 1,2,3 at three successive boundaries; busy_o drops at the third; then 3 -> 0 steps down 2,1,0.
REQ-036 SHALL cover: duty_valid_i with duty 9 held while busy -> ignored; target unchanged; duty 9 accepted once duty_ready_o=1.
REQ-037 SHALL cover: capture on boundary cycle -> no change this boundary; applied at the boundary 64 clk later.
REQ-038 SHALL cover: rst_i asserted mid-ramp (cur_duty=2, target=7) -> all outputs as in REQ-027 asynchronously; after release duty stays 0 until a new write.
